// File: rtl/ioctl_loader.sv
// ioctl_loader
// Accepts a byte stream from the host ioctl download port, buffers it in a
// small FIFO and replays each byte as a one-hot write request to one of NCH
// memory channels. The channel is picked by ioctl_index[2:0] when the
// download starts.
//
// Parameters
//   AW    : ioctl / memory address width
//   DEPTH : FIFO depth in bytes (power of 2, >= 2)
//   NCH   : number of memory channels (1..8)
//
// Ports
//   clk_sys        : single rising-edge clock
//   reset_n        : asynchronous active-low reset
//   ioctl_download : host transfer active
//   ioctl_index    : transfer index, bits [2:0] select the channel
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address
//   ioctl_data     : byte data
//   ioctl_wait     : registered backpressure to the host
//   mem_req        : one-hot write request, held until acknowledged
//   mem_addr       : write address, held with mem_req
//   mem_data       : write data, held with mem_req
//   mem_ack        : per-channel write acknowledge
//   busy           : high while loading or draining
//   done           : one-cycle pulse when a transfer has fully drained
//   err            : sticky error (bad channel or dropped byte)
//   byte_count     : bytes accepted in this transfer, saturating
module ioctl_loader #(
    parameter int AW    = 25,
    parameter int DEPTH = 4,
    parameter int NCH   = 2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          ioctl_wait,
    output logic [NCH-1:0] mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    input  logic [NCH-1:0] mem_ack,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   byte_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
    localparam logic [PW:0] WAIT_LVL = (PW+1)'(DEPTH-1);
    localparam logic [3:0]  NCH_LVL  = 4'(NCH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic          dl_prev;
    logic          start_pend;
    logic [2:0]    chan;
    logic [PW:0]   count, count_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          issue_pend;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [7:0]    fifo_data [DEPTH];

    logic          dl_rise, dl_fall, start, chan_bad, index_bad;
    logic [NCH-1:0] req_onehot;
    logic          ack_sel, req_active, port_free, active;
    logic          wr_ok, push, drop, pop;

    // Upper index bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^ioctl_index[7:3];

    // Edge detection, channel decode and FIFO push/pop decisions. The memory
    // port is free when nothing is staged and any live request is being
    // acknowledged right now, which lets the next pop overlap the ack.
    always_comb begin
        dl_rise   = ioctl_download & ~dl_prev;
        dl_fall   = ~ioctl_download & dl_prev;
        start     = dl_rise | (start_pend & ioctl_download);
        chan_bad  = {1'b0, chan} >= NCH_LVL;
        index_bad = {1'b0, ioctl_index[2:0]} >= NCH_LVL;
        for (int i = 0; i < NCH; i++) begin
            req_onehot[i] = (chan == 3'(i));
        end
        ack_sel    = |(mem_ack & req_onehot);
        req_active = |mem_req;
        port_free  = ~issue_pend & (~req_active | ack_sel);
        active     = (state == LOAD) || (state == DRAIN);
        wr_ok      = (state == LOAD) && ioctl_wr && !chan_bad;
        push       = wr_ok && (count < FULL_LVL);
        drop       = wr_ok && (count == FULL_LVL);
        pop        = active && port_free && (count != '0);
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN finishes on the cycle the last ack is sampled.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (dl_fall) state_next = DRAIN;
            DRAIN:   if ((count == '0) && port_free) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state == LOAD) || (state == DRAIN);
        done = (state == DONE);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ioctl_addr;
            fifo_data[wr_ptr] <= ioctl_data;
        end
    end

    // Transfer bookkeeping, FIFO pointers and the memory request port.
    // dl_prev resets high so a download held through reset is not mistaken
    // for a fresh start. A rise seen while still busy is remembered and
    // honoured once back in IDLE if the host is still downloading.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev    <= 1'b1;
            start_pend <= 1'b0;
            chan       <= '0;
            byte_count <= '0;
            err        <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            issue_pend <= 1'b0;
            mem_req    <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;

            if (state == IDLE) begin
                start_pend <= 1'b0;
            end else if (dl_rise) begin
                start_pend <= 1'b1;
            end

            if ((state == IDLE) && start) begin
                chan       <= ioctl_index[2:0];
                byte_count <= '0;
                err        <= index_bad;
            end else begin
                if (push && (byte_count != '1)) begin
                    byte_count <= byte_count + 1'b1;
                end
                if (drop) begin
                    err <= 1'b1;
                end
            end

            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                mem_addr <= fifo_addr[rd_ptr];
                mem_data <= fifo_data[rd_ptr];
            end

            // A popped byte is presented one cycle after the pop.
            issue_pend <= pop;
            if (issue_pend) begin
                mem_req <= req_onehot;
            end else if (ack_sel) begin
                mem_req <= '0;
            end

            ioctl_wait <= ((state_next == LOAD) || (state_next == DRAIN)) &&
                          (count_next >= WAIT_LVL);
        end
    end

endmodule
